// File: rtl/enokida_trace_pkg.sv
// enokida_trace_pkg: shared record width, memory-flag bit position and capture state encoding
package enokida_trace_pkg;
  localparam int TRACE_WIDTH  = 160;
  localparam int MEM_FLAG_BIT = 159;
  typedef enum logic [1:0] {DISABLED, CAPTURE, OVERFLOW} state_t;
endpackage

// File: rtl/enokida_trace_fifo_mem.sv
// enokida_trace_fifo_mem: DEPTH x WIDTH register array, one sync write port, one async read port
//   clk              clock
//   wr_en/addr/data  write port, written on rising edge
//   rd_addr/rd_data  combinational read port
module enokida_trace_fifo_mem #(
  parameter int WIDTH = enokida_trace_pkg::TRACE_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/enokida_trace_buffer.sv
// enokida_trace_buffer: filters tracer records into a FWFT FIFO feeding the trace-assisted cache
//   clk, rst_n                   clock, async active-low reset
//   cfg_enable_i                 capture enable
//   tracer_valid_i/data_i        incoming trace record
//   trace_pop_i                  consume head record
//   trace_in/trace_ready         head record (0 when empty) and non-empty flag
//   trace_capture_enable         registered cfg_enable_i
//   lock                         overflow indication
//   occupancy_o, dropped_count_o entries held, saturating count of records lost to overflow
module enokida_trace_buffer #(
  parameter int TRACE_WIDTH = enokida_trace_pkg::TRACE_WIDTH,
  parameter int DEPTH       = 8,
  parameter int FILTER_MEM  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_enable_i,
  input  logic                     tracer_valid_i,
  input  logic [TRACE_WIDTH-1:0]   tracer_data_i,
  input  logic                     trace_pop_i,
  output logic [TRACE_WIDTH-1:0]   trace_in,
  output logic                     trace_ready,
  output logic                     trace_capture_enable,
  output logic                     lock,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [31:0]              dropped_count_o
);
  import enokida_trace_pkg::*;
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nxt;
  logic [AW:0] wr_ptr, rd_ptr, occ_nxt;
  logic [TRACE_WIDTH-1:0] rd_data;
  logic push, pop, full, wr_en, drop;
  // pointers carry an extra MSB so wr-rd spans 0..DEPTH
  assign occupancy_o = wr_ptr - rd_ptr;
  assign trace_ready = occupancy_o != '0;
  assign trace_in    = trace_ready ? rd_data : '0;
  always_comb begin
    push    = tracer_valid_i && state != DISABLED && (FILTER_MEM == 0 || tracer_data_i[MEM_FLAG_BIT]);
    pop     = trace_pop_i && trace_ready;
    full    = occupancy_o == (AW+1)'(DEPTH);
    wr_en   = push && state == CAPTURE && (!full || pop);
    // once locked, every offered record is lost until the buffer drains
    drop    = push && (state == OVERFLOW || (full && !pop));
    occ_nxt = occupancy_o + (AW+1)'(wr_en) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= DISABLED;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == DISABLED) ? (cfg_enable_i ? CAPTURE : DISABLED)
              : (state == CAPTURE)  ? (drop ? OVERFLOW : cfg_enable_i ? CAPTURE : DISABLED)
              : (occ_nxt == '0)     ? (cfg_enable_i ? CAPTURE : DISABLED)
              : OVERFLOW;
  end
  always_comb begin
    lock = state == OVERFLOW;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      dropped_count_o      <= '0;
      trace_capture_enable <= 1'b0;
    end else begin
      wr_ptr               <= wr_ptr + (AW+1)'(wr_en);
      rd_ptr               <= rd_ptr + (AW+1)'(pop);
      trace_capture_enable <= cfg_enable_i;
      if (drop && dropped_count_o != '1) dropped_count_o <= dropped_count_o + 32'd1;
    end
  enokida_trace_fifo_mem #(.WIDTH(TRACE_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (tracer_data_i),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );
endmodule
